stats_window_feeder: RTL and testbench

Sample buffer and sequencer that feeds the variance/mean engine (`var`). It accepts a time-series sample stream into a circular buffer and launches the engine on each full, non-overlapping window of WIN samples by driving `si`, `ei` and a one-cycle `start`. It answers the engine's `index` reads with `value`, then captures `mean` and `variance` when `done` is seen. It sits between the sample source and the statistics engine in the predictor datapath.

---
 rtl/stats_window_feeder.sv | 148 ++++++++++++++
 tb/tb_stats_window_feeder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : stats_window_feeder
// Purpose  : Circular sample buffer and launch sequencer for the variance/mean
//            engine. Collects a sample stream, launches the engine on each
//            tumbling window of WIN samples, serves its reads, and latches
//            the results it returns.
// Revision : 1.0 - initial release
// ============================================================================
module stats_window_feeder #(
    parameter int DEPTH = 16,   // buffer entries, power of two, >= WIN
    parameter int AW    = 4,    // log2(DEPTH)
    parameter int WIN   = 10    // samples per window, hop = WIN
) (
    input  logic        Clk,
    input  logic        Rst,
    // sample stream
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    // engine launch
    output logic        start,
    output logic [31:0] si,
    output logic [31:0] ei,
    // engine read port
    input  logic [31:0] index,
    output logic [31:0] value,
    // engine results
    input  logic        done,
    input  logic [31:0] mean,
    input  logic [31:0] variance,
    output logic        res_valid,
    output logic [31:0] res_mean,
    output logic [31:0] res_variance,
    output logic        busy
);

    // Window length in the pending-counter width, the number of free slots
    // that remain outside an active window, and the base-pointer hop.
    localparam logic [AW:0]   C_WIN   = (AW+1)'(WIN);
    localparam logic [AW:0]   C_SLACK = (AW+1)'(DEPTH - WIN);
    localparam logic [AW-1:0] C_HOP   = AW'(WIN);
    localparam logic [31:0]   C_WIN32 = 32'(WIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;          // next write slot
    logic [AW-1:0] r_base;        // first slot of the next window to launch
    logic [AW:0]   r_pending;     // samples written since r_base
    logic          r_res_pend;    // results latched, res_valid due next cycle

    logic          w_accept;
    logic [AW:0]   w_extra;       // samples held beyond the active window
    logic          w_unused;

    // While START is still showing, r_pending includes the window being
    // launched; from BUSY on it counts only samples past that window. Either
    // way, accepting is safe while fewer than DEPTH-WIN slots are claimed.
    assign w_extra  = (r_state == ST_START) ? (r_pending - C_WIN) : r_pending;
    assign in_ready = (r_state == ST_IDLE) || (w_extra < C_SLACK);
    assign w_accept = in_valid && in_ready;

    // Engine reads wrap through the buffer; upper address bits are ignored.
    assign value    = r_mem[index[AW-1:0]];
    assign w_unused = ^index[31:AW];

    // Sample storage: not reset, writes are blocked while reset is held.
    always_ff @(posedge Clk) begin
        if (w_accept && !Rst) begin
            r_mem[r_wp] <= in_data;
        end
    end

    // Write pointer advances on every accepted sample, wrapping mod DEPTH.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wp <= '0;
        end else if (w_accept) begin
            r_wp <= r_wp + AW'(1);
        end
    end

    // Launch sequencer with its registered outputs and window bookkeeping.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_pending    <= '0;
            r_res_pend   <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            si           <= '0;
            ei           <= '0;
            res_valid    <= 1'b0;
            res_mean     <= '0;
            res_variance <= '0;
        end else begin
            start      <= 1'b0;
            res_valid  <= r_res_pend;
            r_res_pend <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_pending <= r_pending + {{AW{1'b0}}, w_accept};
                    if (r_pending >= C_WIN) begin
                        r_state <= ST_START;
                        start   <= 1'b1;
                        busy    <= 1'b1;
                        // ei may run past DEPTH; the engine's reads wrap.
                        si      <= 32'(r_base);
                        ei      <= 32'(r_base) + C_WIN32;
                    end
                end

                ST_START: begin
                    // Retire the launched window; keep any same-cycle sample.
                    r_pending <= r_pending - C_WIN + {{AW{1'b0}}, w_accept};
                    r_base    <= r_base + C_HOP;
                    r_state   <= ST_BUSY;
                end

                ST_BUSY: begin
                    r_pending <= r_pending + {{AW{1'b0}}, w_accept};
                    if (done) begin
                        res_mean     <= mean;
                        res_variance <= variance;
                        r_res_pend   <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stats_window_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stats_window_feeder
// Purpose  : Directed self-checking bench for stats_window_feeder with a
//            stub statistics engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stats_window_feeder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start;
    logic [31:0] si, ei;
    logic [31:0] index = '0;
    logic [31:0] value;
    logic        done = 1'b0;
    logic [31:0] mean = '0;
    logic [31:0] variance = '0;
    logic        res_valid;
    logic [31:0] res_mean, res_variance;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Stream-run log
    int          n_start, n_rv, n_acc;
    int          st_cyc [4];
    logic [31:0] st_si  [4];
    logic [31:0] st_ei  [4];
    int          rv_cyc [4];

    logic [31:0] w1 [10] = '{32'd3, 32'd17, 32'd11, 32'd5, 32'd9,
                             32'd10, 32'd11, 32'd15, 32'd8, 32'd12};

    stats_window_feeder #(.DEPTH(16), .AW(4), .WIN(10)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .si           (si),
        .ei           (ei),
        .index        (index),
        .value        (value),
        .done         (done),
        .mean         (mean),
        .variance     (variance),
        .res_valid    (res_valid),
        .res_mean     (res_mean),
        .res_variance (res_variance),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        in_valid = 1'b0;
        done     = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    // Streams n samples (vbase+k) as fast as accepted; a stub engine raises
    // done dly cycles after each observed start (dly=0: never). Cycle c is
    // the period following the c-th edge of the run.
    task automatic run_stream(input int n, input int dly, input int ncyc, input logic [31:0] vbase);
        int   k;
        int   cnt;
        logic acc;
        k = 0; cnt = 0; n_start = 0; n_rv = 0; n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            st_cyc[i] = -1; st_si[i] = '1; st_ei[i] = '1; rv_cyc[i] = -1;
        end
        in_valid = (n > 0);
        in_data  = vbase;
        for (int c = 1; c <= ncyc; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                k++;
                n_acc++;
            end
            in_valid = (k < n);
            in_data  = vbase + 32'(k);
            done     = 1'b0;
            if (start) begin
                if (n_start < 4) begin
                    st_cyc[n_start] = c;
                    st_si[n_start]  = si;
                    st_ei[n_start]  = ei;
                end
                n_start++;
                mean     = 32'(1000 + n_start);
                variance = 32'(2000 + n_start);
                cnt      = dly;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) done = 1'b1;
            end
            if (res_valid) begin
                if (n_rv < 4) rv_cyc[n_rv] = c;
                n_rv++;
            end
        end
        in_valid = 1'b0;
        done     = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_start",    32'(start),     0);
        check("rst_si",       si,             0);
        check("rst_ei",       ei,             0);
        check("rst_res_valid",32'(res_valid), 0);
        check("rst_in_ready", 32'(in_ready),  1);
        check("rst_busy",     32'(busy),      0);

        // ---------------- window 1 ----------------
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = w1[i];
            tick();
        end
        in_valid = 1'b0;
        check("w1_no_early_start", 32'(start), 0);
        tick();
        check("w1_start",     32'(start), 1);
        check("w1_si",        si,         0);
        check("w1_ei",        ei,         10);
        check("w1_busy",      32'(busy),  1);
        tick();
        check("w1_start_1cyc",32'(start), 0);
        index = 32'd3;
        #1;
        check("w1_value3",    value,      5);
        done = 1'b1; mean = 32'd10; variance = 32'd14;
        tick();
        done = 1'b0;
        check("w1_res_mean",  res_mean,       10);
        check("w1_res_var",   res_variance,   14);
        check("w1_rv_not_yet",32'(res_valid), 0);
        check("w1_idle",      32'(busy),      0);
        tick();
        check("w1_rv_pulse",  32'(res_valid), 1);
        tick();
        check("w1_rv_drop",   32'(res_valid), 0);

        // ---------------- wrap: 20 samples ----------------
        do_reset();
        run_stream(20, 5, 35, 32'd0);
        check("wrap_nstart", 32'(n_start),   2);
        check("wrap_st0",    32'(st_cyc[0]), 11);
        check("wrap_st1",    32'(st_cyc[1]), 22);
        check("wrap_si1",    st_si[1],       10);
        check("wrap_ei1",    st_ei[1],       20);
        check("wrap_rv0",    32'(rv_cyc[0]), 18);
        check("wrap_rv1",    32'(rv_cyc[1]), 29);
        index = 32'd17; #1;
        check("wrap_val17",  value, 17);
        index = 32'd12; #1;
        check("wrap_val12",  value, 12);

        // ---------------- backpressure ----------------
        do_reset();
        run_stream(30, 0, 25, 32'd100);
        check("bp_nstart",   32'(n_start),  1);
        check("bp_accepts",  32'(n_acc),    16);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_busy",     32'(busy),     1);
        for (int i = 0; i < 10; i++) begin
            index = 32'(i);
            #1;
            check("bp_window_kept", value, 32'(100 + i));
        end
        done = 1'b1; mean = 32'd55; variance = 32'd66;
        tick();
        done = 1'b0;
        check("bp_res_mean", res_mean,       55);
        check("bp_release",  32'(in_ready),  1);
        check("bp_rv_wait",  32'(res_valid), 0);
        tick();
        check("bp_rv_pulse", 32'(res_valid), 1);

        // ---------------- same-cycle accept + launch ----------------
        do_reset();
        run_stream(30, 5, 45, 32'd0);
        check("sc_nstart",   32'(n_start),   3);
        check("sc_accepts",  32'(n_acc),     30);
        check("sc_st1",      32'(st_cyc[1]), 22);
        check("sc_st2",      32'(st_cyc[2]), 33);
        check("sc_si2",      st_si[2],       4);
        check("sc_ei2",      st_ei[2],       14);
        check("sc_rv2",      32'(rv_cyc[2]), 40);
        check("sc_res_mean", res_mean,       1003);
        check("sc_res_var",  res_variance,   2003);
        index = 32'd13; #1;
        check("sc_val13",    value,          29);

        // ---------------- reset mid-BUSY ----------------
        do_reset();
        run_stream(10, 0, 14, 32'd0);
        check("rb_busy_before", 32'(busy), 1);
        #2;
        Rst = 1'b1;
        #1;
        check("rb_busy",      32'(busy),      0);
        check("rb_start",     32'(start),     0);
        check("rb_si",        si,             0);
        check("rb_ei",        ei,             0);
        check("rb_in_ready",  32'(in_ready),  1);
        check("rb_res_valid", 32'(res_valid), 0);
        tick();
        Rst = 1'b0;
        n_rv = 0;
        done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (res_valid) n_rv++;
        end
        done = 1'b0;
        check("rb_no_rv",     32'(n_rv), 0);
        run_stream(10, 5, 20, 32'd500);
        check("rb_nstart",    32'(n_start),   1);
        check("rb_st0",       32'(st_cyc[0]), 11);
        check("rb_si0",       st_si[0],       0);
        check("rb_ei0",       st_ei[0],       10);
        check("rb_rv0",       32'(rv_cyc[0]), 18);
        index = 32'd9; #1;
        check("rb_val9",      value,          509);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
